rfphoenix_mem_resp_arbiter: RTL and testbench
=============================================

Name: rfphoenix_mem_resp_arbiter

Overview:
Drains NSRC memory-response FIFOs onto the single register-file writeback port of the rfPhoenix core. The FIFOs are xpm_fifo_sync, standard mode, read latency 1. Sources are granted round-robin, one response is sequenced at a time through a 4-state FSM, and responses whose thread is rolled back while in flight are discarded. The block sits between the memory response FIFOs and the writeback/commit stage.

Parameters:
NSRC, 4, number of response FIFOs arbitrated (2..8)
SW, $clog2(NSRC) (min 1), width of the grant index

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
src_empty  input  NSRC  per-FIFO empty flag
src_v  input  NSRC  per-FIFO data_valid
src_dout  input  NSRC x MemoryArg_t  per-FIFO dout, unpacked [0:NSRC-1]
src_rd  output  NSRC  per-FIFO rd_en; registered, one-hot or zero
rollback  input  NTHREADS  per-thread rollback pulse
wb_v  output  1  writeback valid
wb_arg  output  MemoryArg_t  response being written back
wb_ready  input  1  writeback stage accepts wb_arg this cycle
wb_src  output  SW  source index of wb_arg
busy  output  1  FSM not in IDLE
drop  output  1  one-cycle pulse when a response is discarded by rollback

Behaviour:
- Reset is asynchronous, rst=1 forces:
  - state=IDLE, src_rd=0, hold_v=0, wb_arg=0, wb_src=0, last=NSRC-1, drop=0.
  - busy=0 and wb_v=0 follow from those values.
  - Reset mid-transaction abandons everything. The FIFOs share rst, so no orphaned read data exists.
- Round-robin: candidates = ~src_empty. Pick the first candidate scanning last+1, last+2, ... modulo NSRC. last updates to the grant when the grant is issued.
- IDLE:
  - If any candidate: register src_rd[g]=1, wb_src<=g, last<=g, go to REQ.
  - Otherwise stay in IDLE, src_rd=0.
- REQ: src_rd is high for exactly this cycle. Clear it, go to WAIT.
- WAIT (FIFO output valid this cycle):
  - If src_v[wb_src]=1:
    - If rollback[src_dout[wb_src].thread]=1: discard, pulse drop, go to IDLE.
    - Otherwise wb_arg<=src_dout[wb_src], hold_v<=1, go to HOLD.
  - If src_v=0, remain in WAIT. This is a protocol violation; assert it in simulation.
- HOLD:
  - wb_v = hold_v & ~rollback[wb_arg.thread], combinational.
  - If rollback[wb_arg.thread]=1: hold_v<=0, pulse drop, go to IDLE. Rollback beats wb_ready in the same cycle, and the consumer sees wb_v=0.
  - Else if wb_ready=1: hold_v<=0, go to IDLE.
  - Otherwise hold; wb_arg stays stable.
- Latency from a source going non-empty (sampled in IDLE) to wb_v: 3 cycles (IDLE, REQ, WAIT, then HOLD asserts wb_v). Minimum spacing between accepted responses is 4 cycles.
- Rollback of a thread other than wb_arg.thread has no effect on the held response.
- src_empty changing while in REQ/WAIT/HOLD is ignored until the next IDLE.
- busy = (state != IDLE).
- No change is made to FIFO rollback bitmaps; those are owned by the FIFO.

Optional Feature:
- Macro RFPHOENIX_MEM_RESP_ARB_STATS_EN.
- Defined: adds outputs stat_grant [0:NSRC-1] (32-bit counts of issued src_rd per source) and stat_drop (32-bit count of drop pulses).
  - Counters reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rfPhoenixPkg supplies MemoryArg_t (fields thread, tgt used) and NTHREADS.
- Add to rfPhoenixPkg an enum typedef MemRespArbState_t {IDLE, REQ, WAIT, HOLD}.
- One sub-module, rfphoenix_rr_pick: combinational round-robin picker with inputs req[NSRC] and last[SW], outputs gnt_v and gnt[SW].

Test Plan:
- After reset, all FIFOs empty: src_rd=0, wb_v=0, busy=0 for 20 cycles; wb_src=0.
- Source 2 holds one entry {thread=1, tgt=5}: src_rd=4'b0100 exactly one cycle; wb_v rises 3 cycles after IDLE sample with wb_arg.tgt=5 and wb_src=2; wb_ready=1 returns FSM to IDLE.
- Sources 0, 1, 3 each hold 2 entries, wb_ready tied 1: grant order 0,1,3,0,1,3; accepted responses spaced 4 cycles apart.
- Held response thread=2 with wb_ready=0 for 5 cycles, then rollback[2] and wb_ready=1 in the same cycle: wb_v=0 that cycle, drop=1, no acceptance; FSM returns to IDLE.
- rollback[0] asserted in the WAIT cycle for a response with thread=0: drop=1, wb_v never rises; rollback[1] in HOLD for a thread=0 response leaves wb_v=1.
- rst asserted during HOLD: src_rd, wb_v and busy go to 0 asynchronously. With RFPHOENIX_MEM_RESP_ARB_STATS_EN defined, stat_grant and stat_drop read 0 after reset and match the issued/dropped counts in the prior scenarios.

Source files
------------

// File: rtl/rfPhoenixPkg.sv
// Shared rfPhoenix types: memory response argument, thread count and the
// response-arbiter state encoding.
package rfPhoenixPkg;

    localparam int NTHREADS = 4;
    localparam int TW       = $clog2(NTHREADS);

    typedef struct packed {
        logic [TW-1:0] thread;
        logic [5:0]    tgt;
        logic [31:0]   res;
    } MemoryArg_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} MemRespArbState_t;

endpackage

// File: rtl/rfphoenix_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', modulo NSRC.
module rfphoenix_rr_pick #(
    parameter int NSRC = 4,
    parameter int SW   = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [SW-1:0]   last,
    output logic            gnt_v,
    output logic [SW-1:0]   gnt
);

    logic [SW-1:0] idx;

    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 1; i <= NSRC; i++) begin
            idx = SW'((int'(last) + i) % NSRC);
            if (!gnt_v && req[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
    end

endmodule

// File: rtl/rfphoenix_mem_resp_arbiter.sv
// Drains NSRC memory-response FIFOs (read latency 1) onto the writeback port.
// Optional statistics counters: define RFPHOENIX_MEM_RESP_ARB_STATS_EN.
//
// state | meaning
// IDLE  | pick next non-empty source, pulse its rd_en
// REQ   | rd_en high this cycle; FIFO presents data next cycle
// WAIT  | FIFO dout valid; capture or discard on rollback
// HOLD  | response offered on wb_v until accepted or rolled back
module rfphoenix_mem_resp_arbiter
    import rfPhoenixPkg::*;
#(
    parameter int NSRC = 4,
    parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     src_empty,
    input  logic [NSRC-1:0]     src_v,
    input  MemoryArg_t          src_dout [0:NSRC-1],
    output logic [NSRC-1:0]     src_rd,
    input  logic [NTHREADS-1:0] rollback,
    output logic                wb_v,
    output MemoryArg_t          wb_arg,
    input  logic                wb_ready,
    output logic [SW-1:0]       wb_src,
    output logic                busy,
    output logic                drop
`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grant [0:NSRC-1],
    output logic [31:0]         stat_drop
`endif
);

    MemRespArbState_t state;
    logic             hold_v;
    logic [SW-1:0]    last;
    logic             gnt_v;
    logic [SW-1:0]    gnt;
    logic [NSRC-1:0]  onehot0;

    assign onehot0 = {{(NSRC-1){1'b0}}, 1'b1};

    rfphoenix_rr_pick #(.NSRC(NSRC), .SW(SW)) u_pick (
        .req   (~src_empty),
        .last  (last),
        .gnt_v (gnt_v),
        .gnt   (gnt)
    );

    // Rollback of the held thread masks the offer in the same cycle.
    assign wb_v = hold_v & ~rollback[wb_arg.thread];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            src_rd <= '0;
            hold_v <= 1'b0;
            wb_arg <= '0;
            wb_src <= '0;
            last   <= SW'(NSRC-1);
            drop   <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_v) begin
                        src_rd <= onehot0 << gnt;
                        wb_src <= gnt;
                        last   <= gnt;
                        state  <= REQ;
                    end else begin
                        src_rd <= '0;
                    end
                end
                REQ: begin
                    src_rd <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (src_v[wb_src]) begin
                        if (rollback[src_dout[wb_src].thread]) begin
                            drop  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            wb_arg <= src_dout[wb_src];
                            hold_v <= 1'b1;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rollback[wb_arg.thread]) begin
                        hold_v <= 1'b0;
                        drop   <= 1'b1;
                        state  <= IDLE;
                    end else if (wb_ready) begin
                        hold_v <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_wait_valid: assert property (@(posedge clk) disable iff (rst)
        (state == WAIT) |-> src_v[wb_src])
        else $error("src_v low in WAIT for source %0d", wb_src);

`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) stat_grant[i] <= '0;
            stat_drop <= '0;
        end else begin
            if (state == IDLE && gnt_v && stat_grant[gnt] != '1)
                stat_grant[gnt] <= stat_grant[gnt] + 32'd1;
            if (drop && stat_drop != '1)
                stat_drop <= stat_drop + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rfphoenix_mem_resp_arbiter.sv
// Directed bench for rfphoenix_mem_resp_arbiter with a latency-1 FIFO model per source.
module tb_rfphoenix_mem_resp_arbiter;
    import rfPhoenixPkg::*;

    localparam int NSRC = 4;
    localparam int SW   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NSRC-1:0]     src_empty;
    logic [NSRC-1:0]     src_v;
    MemoryArg_t          src_dout [0:NSRC-1];
    logic [NSRC-1:0]     src_rd;
    logic [NTHREADS-1:0] rollback;
    logic                wb_v;
    MemoryArg_t          wb_arg;
    logic                wb_ready;
    logic [SW-1:0]       wb_src;
    logic                busy;
    logic                drop;
`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
    logic [31:0]         stat_grant [0:NSRC-1];
    logic [31:0]         stat_drop;
`endif

    int total = 0;
    int bad   = 0;

    rfphoenix_mem_resp_arbiter #(.NSRC(NSRC), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_empty (src_empty),
        .src_v     (src_v),
        .src_dout  (src_dout),
        .src_rd    (src_rd),
        .rollback  (rollback),
        .wb_v      (wb_v),
        .wb_arg    (wb_arg),
        .wb_ready  (wb_ready),
        .wb_src    (wb_src),
        .busy      (busy),
        .drop      (drop)
`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
        ,
        .stat_grant(stat_grant),
        .stat_drop (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: entries pushed by the stimulus, popped on rd_en, dout valid one cycle later.
    MemoryArg_t mem [NSRC][16];
    int         push_cnt [NSRC];
    int         pop_cnt  [NSRC];

    always_comb begin
        src_empty = '1;
        for (int i = 0; i < NSRC; i++) src_empty[i] = (push_cnt[i] == pop_cnt[i]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            src_v <= '0;
            for (int i = 0; i < NSRC; i++) begin
                src_dout[i] <= '0;
                pop_cnt[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_rd[i] && push_cnt[i] != pop_cnt[i]) begin
                    src_dout[i] <= mem[i][pop_cnt[i] % 16];
                    pop_cnt[i]  <= pop_cnt[i] + 1;
                    src_v[i]    <= 1'b1;
                end else begin
                    src_v[i] <= 1'b0;
                end
            end
        end
    end

    task automatic push(input int s, input int th, input int tg);
        MemoryArg_t e;
        e        = '0;
        e.thread = th[TW-1:0];
        e.tgt    = tg[5:0];
        e.res    = 32'hA000 + tg;
        mem[s][push_cnt[s] % 16] = e;
        push_cnt[s] = push_cnt[s] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int exp_src [6] = '{0, 1, 3, 0, 1, 3};
    int exp_tgt [6] = '{16, 20, 28, 17, 21, 29};

    initial begin
        rst      = 1'b1;
        wb_ready = 1'b0;
        rollback = '0;
        for (int i = 0; i < NSRC; i++) push_cnt[i] = 0;
        #2;
        chk("rst_src_rd", 64'(src_rd), 64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with all FIFOs empty.
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_src_rd", 64'(src_rd), 64'h0);
            chk("idle_wb_v",   64'(wb_v),   64'h0);
            chk("idle_busy",   64'(busy),   64'h0);
        end
        chk("idle_wb_src", 64'(wb_src), 64'h0);
        chk("idle_drop",   64'(drop),   64'h0);

        // Sources 0,1,3 with two entries each, consumer always ready.
        for (int j = 0; j < 2; j++) begin
            push(0, 0, 16 + j);
            push(1, 0, 20 + j);
            push(3, 0, 28 + j);
        end
        wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_src_rd", 64'(src_rd), 64'(4'b0001 << exp_src[k]));
            step();
            chk("rr_rd_drop", 64'(src_rd), 64'h0);
            step();
            chk("rr_wb_v",   64'(wb_v),       64'h1);
            chk("rr_wb_src", 64'(wb_src),     64'(exp_src[k]));
            chk("rr_tgt",    64'(wb_arg.tgt), 64'(exp_tgt[k]));
            step();
            chk("rr_accept", 64'(wb_v), 64'h0);
        end
        chk("rr_idle", 64'(busy), 64'h0);

        // Single entry in source 2.
        push(2, 1, 5);
        step();
        chk("s2_src_rd", 64'(src_rd), 64'h4);
        chk("s2_busy",   64'(busy),   64'h1);
        step();
        chk("s2_rd_once", 64'(src_rd), 64'h0);
        chk("s2_wb_v_lo", 64'(wb_v),   64'h0);
        step();
        chk("s2_wb_v",   64'(wb_v),       64'h1);
        chk("s2_tgt",    64'(wb_arg.tgt), 64'h5);
        chk("s2_wb_src", 64'(wb_src),     64'h2);
        step();
        chk("s2_done_v",    64'(wb_v), 64'h0);
        chk("s2_done_busy", 64'(busy), 64'h0);

        // Held thread 2 response, then rollback and ready together.
        wb_ready = 1'b0;
        push(0, 2, 7);
        step(); step(); step();
        chk("hold_wb_v", 64'(wb_v), 64'h1);
        repeat (5) step();
        chk("hold_wb_v5",  64'(wb_v),       64'h1);
        chk("hold_tgt",    64'(wb_arg.tgt), 64'h7);
        chk("hold_wb_src", 64'(wb_src),     64'h0);
        rollback = 4'b0100;
        wb_ready = 1'b1;
        #1;
        chk("rb_hold_wb_v", 64'(wb_v), 64'h0);
        step();
        rollback = '0;
        wb_ready = 1'b0;
        chk("rb_hold_drop", 64'(drop), 64'h1);
        chk("rb_hold_busy", 64'(busy), 64'h0);
        step();
        chk("rb_hold_drop_pulse", 64'(drop), 64'h0);

        // Rollback during WAIT discards before capture.
        push(1, 0, 9);
        step();
        step();
        rollback = 4'b0001;
        step();
        rollback = '0;
        chk("rb_wait_drop", 64'(drop), 64'h1);
        chk("rb_wait_busy", 64'(busy), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rb_wait_wb_v", 64'(wb_v), 64'h0);
        end

        // Rollback of an unrelated thread leaves the held response alone.
        push(3, 0, 11);
        step(); step(); step();
        chk("other_wb_v",   64'(wb_v),   64'h1);
        chk("other_wb_src", 64'(wb_src), 64'h3);
        rollback = 4'b0010;
        #1;
        chk("other_rb_wb_v", 64'(wb_v), 64'h1);
        step();
        rollback = '0;
        chk("other_rb_wb_v2", 64'(wb_v), 64'h1);
        chk("other_rb_drop",  64'(drop), 64'h0);
        chk("other_rb_busy",  64'(busy), 64'h1);

`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
        chk("stat_grant0", 64'(stat_grant[0]), 64'd3);
        chk("stat_grant1", 64'(stat_grant[1]), 64'd3);
        chk("stat_grant2", 64'(stat_grant[2]), 64'd1);
        chk("stat_grant3", 64'(stat_grant[3]), 64'd3);
        chk("stat_drop",   64'(stat_drop),     64'd2);
`endif

        // Asynchronous reset while in HOLD.
        rst = 1'b1;
        for (int i = 0; i < NSRC; i++) push_cnt[i] = 0;
        #1;
        chk("arst_src_rd", 64'(src_rd), 64'h0);
        chk("arst_wb_v",   64'(wb_v),   64'h0);
        chk("arst_busy",   64'(busy),   64'h0);
        chk("arst_wb_src", 64'(wb_src), 64'h0);
`ifdef RFPHOENIX_MEM_RESP_ARB_STATS_EN
        for (int i = 0; i < NSRC; i++) chk("arst_stat_grant", 64'(stat_grant[i]), 64'h0);
        chk("arst_stat_drop", 64'(stat_drop), 64'h0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_wb_v", 64'(wb_v), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
